// File: rtl/pipelined_cla_alu_adder.sv
// Pipelined WIDTH-bit add / subtract-with-borrow built from 4-bit CLA groups.
// Each stage resolves one slice; the carry is registered into the next stage.

module pipelined_cla_alu_adder_slice #(
   parameter int GROUPS = 2
) (
   input  logic [4*GROUPS-1:0] i_x,
   input  logic [4*GROUPS-1:0] i_y,
   input  logic                i_c,
   output logic [4*GROUPS-1:0] o_s,
   output logic                o_c,
   output logic                o_cmsb
);
   localparam int B  = 4*GROUPS;
   localparam int LN = (GROUPS > 4) ? GROUPS : 4;

   logic [B-1:0]      w_g, w_p, w_cb;
   logic [LN-1:0]     w_gm, w_pm;
   logic [GROUPS-1:0] w_cg;

   // Flat sum-of-products carry into position j: G[j-1] | P[j-1]G[j-2] | ... | P[j-1:0]c0
   function automatic logic f_carry(input logic [LN-1:0] g, input logic [LN-1:0] p,
                                    input logic c0, input int j);
      logic c, t;
      c = c0;
      for (int m = 0; m < LN; m++) if (m < j) c = c & p[m];
      for (int i = 0; i < LN; i++) begin
         if (i < j) begin
            t = g[i];
            for (int m = 0; m < LN; m++) if (m > i && m < j) t = t & p[m];
            c = c | t;
         end
      end
      return c;
   endfunction

   function automatic logic [LN-1:0] f_ext4(input logic [3:0] v);
      f_ext4      = '0;
      f_ext4[3:0] = v;
   endfunction

   assign w_g = i_x & i_y;
   assign w_p = i_x ^ i_y;

   always_comb begin
      w_gm = '0;
      w_pm = '0;
      w_cg = '0;
      w_cb = '0;
      for (int gi = 0; gi < GROUPS; gi++) begin
         w_gm[gi] = f_carry(f_ext4(w_g[gi*4 +: 4]), f_ext4(w_p[gi*4 +: 4]), 1'b0, 4);
         w_pm[gi] = &w_p[gi*4 +: 4];
      end
      for (int gi = 0; gi < GROUPS; gi++)
         w_cg[gi] = f_carry(w_gm, w_pm, i_c, gi);
      for (int gi = 0; gi < GROUPS; gi++)
         for (int b = 0; b < 4; b++)
            w_cb[gi*4+b] = f_carry(f_ext4(w_g[gi*4 +: 4]), f_ext4(w_p[gi*4 +: 4]), w_cg[gi], b);
   end

   assign o_c    = f_carry(w_gm, w_pm, i_c, GROUPS);
   assign o_cmsb = w_cb[B-1];
   assign o_s    = w_p ^ w_cb;
endmodule

module pipelined_cla_alu_adder #(
   parameter int WIDTH            = 32,
   parameter int GROUPS_PER_STAGE = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] X,
   input  logic [WIDTH-1:0] Y,
   input  logic             Cin,
   input  logic             SUB,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] F,
   output logic             Cout,
   output logic             V,
   output logic             Z,
   output logic             N
);
   localparam int B      = 4*GROUPS_PER_STAGE;
   localparam int NSTAGE = WIDTH/B;

   // Level 0 holds the conditioned operands; level k+1 holds the result of slice k.
   logic [NSTAGE:0]                  r_vld, r_c;
   logic [NSTAGE:0][WIDTH-1:0]       r_f;
   logic [NSTAGE-1:0][WIDTH-1:0]     r_x, r_y;
   logic                             r_v, r_z, r_n;
   logic [NSTAGE-1:0][B-1:0]         w_s;
   logic [NSTAGE-1:0]                w_co, w_cm;
   logic [NSTAGE-1:0][WIDTH-1:0]     w_f_nxt;
   logic                             w_en;
   logic                             w_unused;

   assign w_en     = !r_vld[NSTAGE] | out_ready;
   assign in_ready = w_en;

   genvar k;
   generate
      for (k = 0; k < NSTAGE; k++) begin : g_stage
         pipelined_cla_alu_adder_slice #(.GROUPS(GROUPS_PER_STAGE)) u_slice (
            .i_x    (r_x[k][k*B +: B]),
            .i_y    (r_y[k][k*B +: B]),
            .i_c    (r_c[k]),
            .o_s    (w_s[k]),
            .o_c    (w_co[k]),
            .o_cmsb (w_cm[k])
         );
      end
   endgenerate

   always_comb begin
      w_f_nxt = r_f[NSTAGE-1:0];
      for (int s = 0; s < NSTAGE; s++) w_f_nxt[s][s*B +: B] = w_s[s];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_vld <= '0;
         r_c   <= '0;
         r_f   <= '0;
         r_x   <= '0;
         r_y   <= '0;
         r_v   <= 1'b0;
         r_z   <= 1'b0;
         r_n   <= 1'b0;
      end else if (w_en) begin
         r_vld[0] <= in_valid;
         if (in_valid) begin
            r_x[0] <= X;
            r_y[0] <= SUB ? ~Y : Y;
            r_c[0] <= SUB ? ~Cin : Cin;
            r_f[0] <= '0;
         end
         for (int s = 0; s < NSTAGE; s++) begin
            r_vld[s+1] <= r_vld[s];
            r_f[s+1]   <= w_f_nxt[s];
            r_c[s+1]   <= w_co[s];
         end
         for (int s = 0; s < NSTAGE-1; s++) begin
            r_x[s+1] <= r_x[s];
            r_y[s+1] <= r_y[s];
         end
         r_v <= w_cm[NSTAGE-1] ^ w_co[NSTAGE-1];
         r_z <= ~|w_f_nxt[NSTAGE-1];
         r_n <= w_f_nxt[NSTAGE-1][WIDTH-1];
      end
   end

   // Operand bits below a stage's slice are already consumed and never read again.
   assign w_unused = ^{r_x, r_y};

   assign out_valid = r_vld[NSTAGE];
   assign F         = r_f[NSTAGE];
   assign Cout      = r_c[NSTAGE];
   assign V         = r_v;
   assign Z         = r_z;
   assign N         = r_n;
endmodule

// File: tb/tb_pipelined_cla_alu_adder.sv
// Bench for pipelined_cla_alu_adder: directed table, latency, throughput,
// backpressure, random traffic against an arithmetic model, async reset.
module tb_pipelined_cla_alu_adder;
   typedef struct packed {
      logic [31:0] f;
      logic        c, v, z, n;
   } res_t;

   typedef struct {
      logic [31:0] x, y;
      logic        cin, sub;
      res_t        r;
   } vec_t;

   logic        clk, rst_n, in_valid, in_ready, Cin, SUB, out_valid, out_ready;
   logic        Cout, V, Z, N;
   logic [31:0] X, Y, F;

   int   total = 0, bad = 0;
   int   npop = 0, run = 0, last_run = 0;
   res_t exp_q[$];
   res_t cur_exp, e;
   logic rand_rdy;
   logic hold_pend = 1'b0;
   logic [63:0] hold_val;

   pipelined_cla_alu_adder dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .X(X), .Y(Y), .Cin(Cin), .SUB(SUB), .out_valid(out_valid), .out_ready(out_ready),
      .F(F), .Cout(Cout), .V(V), .Z(Z), .N(N)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #5_000_000;
      $display("FAIL global_timeout act=running req=finished");
      $fatal(1, "timeout");
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s act=%h req=%h t=%0t", nm, act, req, $time);
      end
   endtask

   function automatic res_t model(input logic [31:0] x, y, input logic cin, sub);
      longint ux, uy, sx, sy, ci, u, s;
      res_t r;
      ux = longint'(x); uy = longint'(y);
      sx = longint'($signed(x)); sy = longint'($signed(y));
      ci = cin ? 1 : 0;
      if (!sub) begin
         u = ux + uy + ci; s = sx + sy + ci;
         r.c = (u >= 64'sd4294967296);
      end else begin
         u = ux - uy - ci; s = sx - sy - ci;
         r.c = (u >= 0);
      end
      r.f = u[31:0];
      r.v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      r.z = (r.f == 32'd0);
      r.n = r.f[31];
      return r;
   endfunction

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 5))
         0:       return 32'h0000_0000;
         1:       return 32'hFFFF_FFFF;
         2:       return 32'h8000_0000;
         3:       return 32'h7FFF_FFFF;
         default: return $urandom;
      endcase
   endfunction

   // Scoreboard: pop on output handshake, push on input handshake, hold check on stall.
   always @(negedge clk) begin
      if (!rst_n) begin
         exp_q.delete();
         hold_pend = 1'b0;
         run = 0;
      end else begin
         if (hold_pend) chk("stall_hold", 64'({out_valid, F, Cout, V, Z, N}), hold_val);
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) chk("spurious_out", 64'(0), 64'(1));
            else begin
               e = exp_q.pop_front();
               chk("result", 64'({F, Cout, V, Z, N}), 64'(e));
            end
            npop++;
         end
         if (in_valid && in_ready) exp_q.push_back(cur_exp);
         hold_pend = out_valid && !out_ready;
         hold_val  = 64'({out_valid, F, Cout, V, Z, N});
         if (out_valid) run++;
         else begin
            if (run != 0) last_run = run;
            run = 0;
         end
      end
   end

   task automatic tick_rdy();
      if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk); #1;
         tick_rdy();
      end
   endtask

   task automatic send(input logic [31:0] x, y, input logic c, s, input res_t r, output int w);
      w = 0;
      X = x; Y = y; Cin = c; SUB = s; cur_exp = r; in_valid = 1'b1;
      forever begin
         @(negedge clk); w++;
         if (in_ready) break;
         if (w >= 200) begin
            chk("accept_timeout", 64'(0), 64'(1));
            break;
         end
         @(posedge clk); #1;
         tick_rdy();
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      tick_rdy();
   endtask

   vec_t        tbl[8];
   int          w, p0;
   logic [31:0] rx, ry;
   logic        rc, rs;

   initial begin
      tbl[0] = '{32'h1,        32'h2, 1'b0, 1'b0, '{32'h3,        1'b0, 1'b0, 1'b0, 1'b0}};
      tbl[1] = '{32'hFFFFFFFF, 32'h0, 1'b1, 1'b0, '{32'h0,        1'b1, 1'b0, 1'b1, 1'b0}};
      tbl[2] = '{32'h7FFFFFFF, 32'h1, 1'b0, 1'b0, '{32'h80000000, 1'b0, 1'b1, 1'b0, 1'b1}};
      tbl[3] = '{32'h5,        32'h7, 1'b0, 1'b1, '{32'hFFFFFFFE, 1'b0, 1'b0, 1'b0, 1'b1}};
      tbl[4] = '{32'h7,        32'h5, 1'b1, 1'b1, '{32'h1,        1'b1, 1'b0, 1'b0, 1'b0}};
      tbl[5] = '{32'h80000000, 32'h1, 1'b0, 1'b1, '{32'h7FFFFFFF, 1'b1, 1'b1, 1'b0, 1'b0}};
      tbl[6] = '{32'h5,        32'h5, 1'b0, 1'b1, '{32'h0,        1'b1, 1'b0, 1'b1, 1'b0}};
      tbl[7] = '{32'h0,        32'h0, 1'b1, 1'b1, '{32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 1'b1}};

      rst_n = 1'b0; in_valid = 1'b1; X = 32'h1234_5678; Y = 32'h0F0F_0F0F;
      Cin = 1'b0; SUB = 1'b0; out_ready = 1'b1; rand_rdy = 1'b0; cur_exp = '0;

      repeat (4) begin
         @(negedge clk);
         chk("reset_outputs", 64'({out_valid, F, Cout, V, Z, N}), 64'(0));
      end
      @(posedge clk); #1;
      in_valid = 1'b0; rst_n = 1'b1;
      @(negedge clk);
      chk("reset_in_ready", 64'(in_ready), 64'(1));
      @(posedge clk); #1;

      // first beat: four edges of latency after the accept edge
      send(tbl[0].x, tbl[0].y, tbl[0].cin, tbl[0].sub, tbl[0].r, w);
      repeat (4) begin
         @(negedge clk);
         chk("latency_early", 64'(out_valid), 64'(0));
      end
      @(negedge clk);
      chk("latency_valid", 64'({out_valid, F}), 64'({1'b1, 32'h3}));
      @(posedge clk); #1;

      p0 = npop;
      for (int i = 1; i < 8; i++) send(tbl[i].x, tbl[i].y, tbl[i].cin, tbl[i].sub, tbl[i].r, w);
      idle(8);
      chk("table_pops", 64'(npop - p0), 64'(7));

      p0 = npop;
      for (int i = 0; i < 16; i++) begin
         rx = pick(); ry = pick(); rc = 1'($urandom_range(0, 1)); rs = 1'($urandom_range(0, 1));
         send(rx, ry, rc, rs, model(rx, ry, rc, rs), w);
         chk("tput_in_ready", 64'(w), 64'(1));
      end
      idle(8);
      chk("tput_run", 64'(last_run), 64'(16));
      chk("tput_pops", 64'(npop - p0), 64'(16));

      // fill the pipe with the output stalled, then pop and push on one edge
      out_ready = 1'b0; p0 = npop;
      for (int i = 0; i < 5; i++) begin
         rx = $urandom; ry = $urandom; rs = 1'($urandom_range(0, 1));
         send(rx, ry, 1'b0, rs, model(rx, ry, 1'b0, rs), w);
      end
      rx = $urandom; ry = $urandom;
      X = rx; Y = ry; Cin = 1'b1; SUB = 1'b0; cur_exp = model(rx, ry, 1'b1, 1'b0); in_valid = 1'b1;
      repeat (3) begin
         @(negedge clk);
         chk("bp_in_ready", 64'(in_ready), 64'(0));
         chk("bp_out_valid", 64'(out_valid), 64'(1));
         @(posedge clk); #1;
      end
      out_ready = 1'b1;
      @(negedge clk);
      chk("bp_accept", 64'(in_ready), 64'(1));
      @(posedge clk); #1;
      in_valid = 1'b0;
      idle(8);
      chk("bp_pops", 64'(npop - p0), 64'(6));
      chk("bp_queue_empty", 64'(exp_q.size()), 64'(0));

      rand_rdy = 1'b1; p0 = npop;
      for (int i = 0; i < 10000; i++) begin
         if ($urandom_range(0, 3) == 0) idle(1);
         rx = pick(); ry = pick(); rc = 1'($urandom_range(0, 1)); rs = 1'($urandom_range(0, 1));
         send(rx, ry, rc, rs, model(rx, ry, rc, rs), w);
      end
      rand_rdy = 1'b0; out_ready = 1'b1;
      idle(10);
      chk("rand_pops", 64'(npop - p0), 64'(10000));
      chk("rand_queue_empty", 64'(exp_q.size()), 64'(0));

      // async reset between edges with a full, stalled pipe
      out_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         rx = $urandom; ry = $urandom;
         send(rx, ry, 1'b0, 1'b0, model(rx, ry, 1'b0, 1'b0), w);
      end
      @(negedge clk); #2;
      rst_n = 1'b0;
      #1;
      chk("areset_outputs", 64'({out_valid, F, Cout, V, Z, N}), 64'(0));
      chk("areset_in_ready", 64'(in_ready), 64'(1));
      @(negedge clk);
      @(posedge clk); #1;
      rst_n = 1'b1; out_ready = 1'b1; p0 = npop;
      idle(10);
      chk("areset_no_stale", 64'(npop - p0), 64'(0));
      send(32'hDEAD_BEEF, 32'h2152_4111, 1'b0, 1'b0, model(32'hDEAD_BEEF, 32'h2152_4111, 1'b0, 1'b0), w);
      idle(8);
      chk("areset_recover_pops", 64'(npop - p0), 64'(1));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
